store_buffer: RTL and testbench

Word-store queue between the EX/MEM pipeline register and the data memory. It accepts committed `sw` operations from the MEM stage and drains them into the DM write port one per cycle. It forwards pending store data to same-address loads, so the MEM stage never waits on a DM write except when the queue is full.

---
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : Word-store queue between the EX/MEM register and data memory.
//            Accepts committed stores, drains them to the DM write port one
//            per cycle in program order, and checks MEM-stage loads against
//            pending stores.
// Macro    : SB_FWD_EN - when defined, matching loads are forwarded the
//            youngest pending store word (ld_stall tied 0). When undefined,
//            a matching load raises ld_stall and ld_data is dm_rdata.
// Ports    :
//   clk, reset            clock, asynchronous active-low reset
//   st_valid/addr/data/pc store request from MEM stage; st_ready = not full
//   ld_addr, dm_rdata     load address and DM combinational read data
//   ld_data, ld_hit       load result after forwarding, forwarded flag
//   ld_stall              load collides with a pending store (no forwarding)
//   dm_busy               DM write port unavailable this cycle
//   dm_we/addr/wdata/pc   DM write port driven from the head entry
//   count, empty          occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [31:0]      st_pc,
  output logic             st_ready,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      dm_rdata,
  output logic [31:0]      ld_data,
  output logic             ld_hit,
  output logic             ld_stall,
  input  logic             dm_busy,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [31:0]      dm_pc,
  output logic [PTR_W:0]   count,
  output logic             empty
);

  localparam logic [PTR_W:0]   C_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  // Entry storage: word address, data and PC. Not reset; validity comes
  // solely from head/count.
  logic [29:0] r_addr [DEPTH];
  logic [31:0] r_data [DEPTH];
  logic [31:0] r_pc   [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_match;
  logic [31:0] w_fwd_data;

  // Byte-offset bits of the addresses are deliberately ignored.
  logic w_unused_bits;
  assign w_unused_bits = ^{ld_addr[1:0], st_addr[1:0]};

  // Full blocks enqueue even when the head drains in the same cycle.
  assign st_ready = (r_count < C_DEPTH);
  assign w_push   = st_valid && st_ready;
  assign w_pop    = (r_count != '0) && !dm_busy;

  assign dm_we    = w_pop;
  assign dm_addr  = {r_addr[r_head], 2'b00};
  assign dm_wdata = r_data[r_head];
  assign dm_pc    = r_pc[r_head];

  assign count    = r_count;
  assign empty    = (r_count == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr[31:2];
      r_data[r_tail] <= st_data;
      r_pc[r_tail]   <= st_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is natural overflow.
      if (w_push) r_tail <= r_tail + C_ONE;
      if (w_pop)  r_head <= r_head + C_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scan from oldest to youngest valid entry; a later match overrides an
  // earlier one so the youngest matching store wins. The head entry stays
  // valid during its drain cycle, so it still matches.
  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_match    = 1'b0;
    w_fwd_data = dm_rdata;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (((PTR_W+1)'(k) < r_count) && (r_addr[w_idx] == ld_addr[31:2])) begin
        w_match = 1'b1;
`ifdef SB_FWD_EN
        w_fwd_data = r_data[w_idx];
`endif
      end
    end
  end

`ifdef SB_FWD_EN
  assign ld_hit   = w_match;
  assign ld_data  = w_fwd_data;
  assign ld_stall = 1'b0;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^w_fwd_data;
  assign ld_hit   = 1'b0;
  assign ld_data  = dm_rdata;
  assign ld_stall = w_match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer. A scoreboard queue mirrors
//            the buffer contents; every DM write is popped and compared, and
//            load forwarding/stall expectations are derived from the queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             st_valid = 1'b0;
  logic [31:0]      st_addr = '0;
  logic [31:0]      st_data = '0;
  logic [31:0]      st_pc = '0;
  logic             st_ready;
  logic [31:0]      ld_addr = '0;
  logic [31:0]      dm_rdata = '0;
  logic [31:0]      ld_data;
  logic             ld_hit;
  logic             ld_stall;
  logic             dm_busy = 1'b0;
  logic             dm_we;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_pc;
  logic [PTR_W:0]   count;
  logic             empty;

  store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc),
    .st_ready(st_ready),
    .ld_addr(ld_addr), .dm_rdata(dm_rdata),
    .ld_data(ld_data), .ld_hit(ld_hit), .ld_stall(ld_stall),
    .dm_busy(dm_busy),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_pc(dm_pc),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } st_t;

  st_t sb[$];
  int  n_total   = 0;
  int  n_pass    = 0;
  int  n_drained = 0;

  // Scoreboard monitor on the falling edge. Between a rising edge (+1) and
  // the next falling edge the queue equals the buffer contents.
  always @(negedge clk) begin
    int  sz;
    st_t e;
    if (!reset) begin
      sb.delete();
    end else begin
      sz = sb.size();
      n_total++;
      if (count !== 3'(sz)) $display("FAIL mon_count: got %0d want %0d", count, sz);
      else n_pass++;
      n_total++;
      if (empty !== (sz == 0)) $display("FAIL mon_empty: got %b want %b", empty, (sz == 0));
      else n_pass++;
      n_total++;
      if (st_ready !== (sz < DEPTH)) $display("FAIL mon_st_ready: got %b want %b", st_ready, (sz < DEPTH));
      else n_pass++;
      n_total++;
      if (dm_we !== ((sz > 0) && !dm_busy)) $display("FAIL mon_dm_we: got %b want %b", dm_we, ((sz > 0) && !dm_busy));
      else n_pass++;
      if (dm_we === 1'b1) begin
        n_total++;
        if (sz == 0) begin
          $display("FAIL mon_spurious_write: dm_we=1 addr=%h with nothing pending", dm_addr);
        end else begin
          e = sb.pop_front();
          n_drained++;
          if ({dm_addr, dm_wdata, dm_pc} !== {e.addr & 32'hFFFF_FFFC, e.data, e.pc})
            $display("FAIL mon_dm_write: got a=%h d=%h pc=%h want a=%h d=%h pc=%h",
                     dm_addr, dm_wdata, dm_pc, e.addr & 32'hFFFF_FFFC, e.data, e.pc);
          else n_pass++;
        end
      end
      if (st_valid && (sz < DEPTH)) begin
        e.addr = st_addr; e.data = st_data; e.pc = st_pc;
        sb.push_back(e);
      end
    end
  end

  // Expected load result from the scoreboard: youngest matching entry.
  function automatic void model_ld(input logic [31:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = dm_rdata;
    foreach (sb[i]) begin
      if (sb[i].addr[31:2] == a[31:2]) begin
        hit = 1'b1;
        d   = sb[i].data;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    st_valid = 1'b1; st_addr = a; st_data = d; st_pc = pc;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && !(sb.size() == 0 && empty === 1'b1); k++) step();
    n_total++;
    if (empty !== 1'b1 || sb.size() != 0)
      $display("FAIL drain_timeout: empty=%b pending=%0d want empty=1 pending=0", empty, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0;
    #3;
    n_total++;
    if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
    n_total++;
    if (st_ready !== 1'b1) $display("FAIL rst_st_ready: got %b want 1", st_ready); else n_pass++;
    n_total++;
    if (dm_we !== 1'b0) $display("FAIL rst_dm_we: got %b want 0", dm_we); else n_pass++;
    n_total++;
    if (ld_hit !== 1'b0) $display("FAIL rst_ld_hit: got %b want 0", ld_hit); else n_pass++;
    n_total++;
    if (ld_stall !== 1'b0) $display("FAIL rst_ld_stall: got %b want 0", ld_stall); else n_pass++;
    step();
    reset = 1'b1;
    // Mid-queue reset: three stores held by dm_busy.
    dm_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h0000_0040 + 32'(4*i), 32'hC0DE_0000 + 32'(i), 32'h0000_0200 + 32'(4*i));
      step();
    end
    st_valid = 1'b0;
    #1;
    n_total++;
    if (count !== 3'd3) $display("FAIL rstq_count_before: got %0d want 3", count); else n_pass++;
    #1;
    reset = 1'b0;
    #1;
    n_total++;
    if (count !== 3'd0) $display("FAIL rstq_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL rstq_empty: got %b want 1", empty); else n_pass++;
    n_total++;
    if (dm_we !== 1'b0) $display("FAIL rstq_dm_we: got %b want 0", dm_we); else n_pass++;
    sb.delete();
    step();
    reset = 1'b1;
    dm_busy = 1'b0;
    base = n_drained;
    repeat (6) step();
    n_total++;
    if (n_drained != base || dm_we !== 1'b0)
      $display("FAIL rstq_no_write: writes=%0d dm_we=%b want writes=0 dm_we=0", n_drained - base, dm_we);
    else n_pass++;
  endtask

  task automatic test_basic_drain();
    dm_busy = 1'b0;
    drive_store(32'h0000_0010, 32'h1234_5678, 32'h0000_0300);
    step();
    st_valid = 1'b0;
    n_total++;
    if (dm_we !== 1'b1 || dm_addr !== 32'h10 || dm_wdata !== 32'h1234_5678)
      $display("FAIL basic_write: we=%b a=%h d=%h want we=1 a=00000010 d=12345678", dm_we, dm_addr, dm_wdata);
    else n_pass++;
    step();
    n_total++;
    if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_full();
    int base;
    base = n_drained;
    dm_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      drive_store(32'h0000_0080 + 32'(4*i), 32'hF000_0000 + 32'(i), 32'h0000_0400 + 32'(4*i));
      step();
    end
    drive_store(32'h0000_00F0, 32'hDEAD_0005, 32'h0000_0500);
    #1;
    n_total++;
    if (st_ready !== 1'b0 || count !== 3'd4)
      $display("FAIL full_state: st_ready=%b count=%0d want st_ready=0 count=4", st_ready, count);
    else n_pass++;
    step();
    st_valid = 1'b0;
    dm_busy = 1'b0;
    #1;
    n_total++;
    if (st_ready !== 1'b0) $display("FAIL full_ready_during_drain: got %b want 0", st_ready); else n_pass++;
    step();
    n_total++;
    if (st_ready !== 1'b1 || count !== 3'd3)
      $display("FAIL full_ready_after_drain: st_ready=%b count=%0d want 1 and 3", st_ready, count);
    else n_pass++;
    wait_drain();
    n_total++;
    if (n_drained - base != DEPTH)
      $display("FAIL full_write_count: got %0d want %0d", n_drained - base, DEPTH);
    else n_pass++;
  endtask

  task automatic test_forward();
    logic        hit;
    logic [31:0] d;
    dm_busy = 1'b1;
    drive_store(32'h0000_0020, 32'hAAAA_AAAA, 32'h0000_0600);
    step();
    drive_store(32'h0000_0020, 32'hBBBB_BBBB, 32'h0000_0604);
    step();
    st_valid = 1'b0;
    dm_rdata = 32'hDEAD_BEEF;
    ld_addr  = 32'h0000_0022;
    #1;
`ifdef SB_FWD_EN
    n_total++;
    if (ld_hit !== 1'b1 || ld_data !== 32'hBBBB_BBBB || ld_stall !== 1'b0)
      $display("FAIL fwd_youngest: hit=%b data=%h stall=%b want 1 bbbbbbbb 0", ld_hit, ld_data, ld_stall);
    else n_pass++;
`else
    n_total++;
    if (ld_stall !== 1'b1 || ld_hit !== 1'b0 || ld_data !== 32'hDEAD_BEEF)
      $display("FAIL nofwd_stall: stall=%b hit=%b data=%h want 1 0 deadbeef", ld_stall, ld_hit, ld_data);
    else n_pass++;
`endif
    ld_addr = 32'h0000_0024;
    #1;
    n_total++;
    if (ld_hit !== 1'b0 || ld_data !== 32'hDEAD_BEEF || ld_stall !== 1'b0)
      $display("FAIL ld_miss: hit=%b data=%h stall=%b want 0 deadbeef 0", ld_hit, ld_data, ld_stall);
    else n_pass++;
    ld_addr = 32'h0000_0022;
    dm_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      model_ld(ld_addr, hit, d);
`ifdef SB_FWD_EN
      n_total++;
      if (ld_hit !== hit || ld_data !== d || ld_stall !== 1'b0)
        $display("FAIL fwd_drain_c%0d: hit=%b data=%h stall=%b want %b %h 0", c, ld_hit, ld_data, ld_stall, hit, d);
      else n_pass++;
`else
      n_total++;
      if (ld_stall !== hit || ld_hit !== 1'b0 || ld_data !== dm_rdata)
        $display("FAIL nofwd_drain_c%0d: stall=%b hit=%b data=%h want %b 0 %h", c, ld_stall, ld_hit, ld_data, hit, dm_rdata);
      else n_pass++;
`endif
      step();
    end
    wait_drain();
    n_total++;
    if (ld_stall !== 1'b0 || ld_hit !== 1'b0)
      $display("FAIL ld_after_drain: stall=%b hit=%b want 0 0", ld_stall, ld_hit);
    else n_pass++;
    ld_addr = '0;
  endtask

  task automatic test_wrap();
    int    i;
    int    cyc;
    int    base;
    logic  acc;
    i = 0; cyc = 0;
    base = n_drained;
    while (i < 10 && cyc < 60) begin
      dm_busy = (cyc % 2) == 1;
      drive_store(32'h0000_0100 + 32'(4*i), 32'h5A5A_0000 + 32'(i), 32'h0000_0800 + 32'(4*i));
      acc = (sb.size() < DEPTH);
      step();
      if (acc) i++;
      cyc++;
      n_total++;
      if (count > 3'd4) $display("FAIL wrap_count_bound: got %0d want <=4", count); else n_pass++;
    end
    st_valid = 1'b0;
    dm_busy  = 1'b0;
    n_total++;
    if (i != 10) $display("FAIL wrap_accept: accepted %0d want 10", i); else n_pass++;
    wait_drain();
    n_total++;
    if (n_drained - base != 10) $display("FAIL wrap_writes: got %0d want 10", n_drained - base); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_drain();
    test_full();
    test_forward();
    test_wrap();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
